// File: rtl/execute_cycle.sv
// RV32 execute stage: forwarding, single-cycle ALU, branch resolve, iterative unsigned mul/div.
// Registers results into the E->M pipeline register; StallE holds upstream while mul/div runs.
module execute_cycle #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FlushE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic              MulDivE,
  input  logic [1:0]        MulDivOpE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [4:0]        RD_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              StallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ALU_ResultM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] src_a, src_b, write_data_e, alu_result;
  logic [DATA_W-1:0] hi_q, lo_q, opnd_q, md_result;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start;
  logic [DATA_W:0]   mul_sum, div_shift;

  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel,
                                            input logic [DATA_W-1:0] rd,
                                            input logic [DATA_W-1:0] res_w,
                                            input logic [DATA_W-1:0] alu_m);
    case (sel)
      2'b01:   fwd = res_w;
      2'b10:   fwd = alu_m;
      default: fwd = rd;
    endcase
  endfunction

  always_comb begin
    src_a        = fwd(ForwardA_E, RD1_E, ResultW, ALU_ResultM);
    write_data_e = fwd(ForwardB_E, RD2_E, ResultW, ALU_ResultM);
    src_b        = ALUSrcE ? Imm_Ext_E : write_data_e;
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b101: alu_result = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  assign PCSrcE    = BranchE & (alu_result == '0) & ~MulDivE & ~FlushE;
  assign PCTargetE = PCE + Imm_Ext_E;
  assign start     = MulDivE & ~FlushE;

  // hi/lo double as product {hi,lo} for mul and {remainder,quotient} for div
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[DATA_W-1]};
  assign md_result = op_q[0] ? hi_q : lo_q;

  always_comb begin
    state_d = state_q;
    StallE  = 1'b0;
    case (state_q)
      IDLE: begin
        StallE = start;
        if (start) state_d = BUSY;
      end
      BUSY: begin
        StallE = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FlushE) state_d = IDLE;
    if (rst)    StallE  = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= '0;
    end else if (FlushE) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q  <= '0;
      op_q   <= MulDivOpE;
      hi_q   <= '0;
      opnd_q <= MulDivOpE[1] ? src_b : src_a;
      lo_q   <= MulDivOpE[1] ? src_a : src_b;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (!op_q[1]) begin
        hi_q <= mul_sum[DATA_W:1];
        lo_q <= {mul_sum[0], lo_q[DATA_W-1:1]};
      end else if (div_shift >= {1'b0, opnd_q}) begin
        hi_q <= DATA_W'(div_shift - {1'b0, opnd_q});
        lo_q <= {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi_q <= div_shift[DATA_W-1:0];
        lo_q <= {lo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE || state_q == BUSY || (state_q == IDLE && start)) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data_e;
      ALU_ResultM <= (state_q == DONE) ? md_result : alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: ALU, branch, forwarding, mul/div, reset and flush behaviour.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulDivE;
  logic [2:0]  ALUControlE;
  logic [1:0]  MulDivOpE, ForwardA_E, ForwardB_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [4:0]  RD_M;
  int total = 0;
  int bad   = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    FlushE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
    MulDivE = 0; ALUControlE = 3'b000; MulDivOpE = 2'b00; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nop();
    step();
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWriteM); end
    total++; if (ALU_ResultM !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", ALU_ResultM); end
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallE); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add;
    nop();
    RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; RegWriteE = 1; RD_E = 3; PCPlus4E = 32'h104; RD2_E = 32'hAB;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL add_pcsrc got=%b exp=0", PCSrcE); end
    step();
    total++; if (ALU_ResultM !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=c", ALU_ResultM); end
    total++; if (RegWriteM !== 1'b1) begin bad++; $display("FAIL add_regwrite got=%b exp=1", RegWriteM); end
    total++; if (RD_M !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", RD_M); end
    total++; if (PCPlus4M !== 32'h104) begin bad++; $display("FAIL add_pc4 got=%h exp=104", PCPlus4M); end
    total++; if (WriteDataM !== 32'hAB) begin bad++; $display("FAIL add_wdata got=%h exp=ab", WriteDataM); end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1;
    total++; if (ALU_ResultM !== 32'h0) begin bad++; $display("FAIL arst_alu got=%h exp=0", ALU_ResultM); end
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL arst_regwrite got=%b exp=0", RegWriteM); end
    rst = 1'b0;
    nop();
    step();
  endtask

  task automatic test_alu_ops;
    logic [2:0]  ctl [7] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b101, 3'b111, 3'b000};
    logic [31:0] va  [7] = '{32'd10, 32'h0000F0F0, 32'h0000F000, 32'hFFFFFFFF, 32'd1, 32'd5, 32'hFFFFFFFF};
    logic [31:0] vb  [7] = '{32'd3, 32'h00000FF0, 32'h0000000F, 32'd1, 32'hFFFFFFFF, 32'd6, 32'd2};
    logic [31:0] ve  [7] = '{32'd7, 32'h000000F0, 32'h0000F00F, 32'd1, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 7; i++) begin
      nop();
      ALUControlE = ctl[i]; RD1_E = va[i]; RD2_E = vb[i]; RegWriteE = 1;
      step();
      total++;
      if (ALU_ResultM !== ve[i]) begin
        bad++; $display("FAIL alu_op%0d got=%h exp=%h", i, ALU_ResultM, ve[i]);
      end
    end
  endtask

  task automatic test_branch;
    nop();
    ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; BranchE = 1; PCE = 32'h100; Imm_Ext_E = 32'h20;
    RegWriteE = 1; RD_E = 4;
    #1;
    total++; if (PCSrcE !== 1'b1) begin bad++; $display("FAIL br_taken got=%b exp=1", PCSrcE); end
    total++; if (PCTargetE !== 32'h120) begin bad++; $display("FAIL br_target got=%h exp=120", PCTargetE); end
    RD2_E = 8;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b exp=0", PCSrcE); end
    RD2_E = 9; FlushE = 1;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL br_flush got=%b exp=0", PCSrcE); end
    step();
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL br_flush_bubble got=%b exp=0", RegWriteM); end
    total++; if (RD_M !== 5'd0) begin bad++; $display("FAIL br_flush_rd got=%0d exp=0", RD_M); end
    nop();
  endtask

  task automatic test_forward;
    nop();
    RD1_E = 1; Imm_Ext_E = 2; ALUSrcE = 1; RegWriteE = 1;
    step();
    RD1_E = 99; Imm_Ext_E = 1; ForwardA_E = 2'b10;
    step();
    total++; if (ALU_ResultM !== 32'd4) begin bad++; $display("FAIL fwd_alum got=%0d exp=4", ALU_ResultM); end
    ForwardA_E = 2'b01; ResultW = 50;
    step();
    total++; if (ALU_ResultM !== 32'd51) begin bad++; $display("FAIL fwd_resw got=%0d exp=51", ALU_ResultM); end
    ForwardA_E = 2'b11; ForwardB_E = 2'b10; RD2_E = 7;
    step();
    total++; if (ALU_ResultM !== 32'd100) begin bad++; $display("FAIL fwd_code11 got=%0d exp=100", ALU_ResultM); end
    total++; if (WriteDataM !== 32'd51) begin bad++; $display("FAIL fwd_wdata got=%0d exp=51", WriteDataM); end
    nop();
  endtask

  task automatic run_muldiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string name);
    int stalls = 0;
    MulDivE = 1; MulDivOpE = op; RD1_E = a; RD2_E = b; ALUSrcE = 0; RegWriteE = 1; RD_E = 7;
    ForwardA_E = 2'b00; ForwardB_E = 2'b00; FlushE = 0;
    #1;
    while (StallE === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #1;
      if (stalls == 1) begin ForwardA_E = 2'b01; ResultW = 32'h5A5A5A5A; end
    end
    ForwardA_E = 2'b00;
    total++; if (stalls != 33) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=33", name, stalls); end
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL %s_busy_bubble got=%b exp=0", name, RegWriteM); end
    step();
    total++; if (ALU_ResultM !== exp) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, ALU_ResultM, exp); end
    total++; if (RegWriteM !== 1'b1 || RD_M !== 5'd7) begin
      bad++; $display("FAIL %s_ctrl got=%b/%0d exp=1/7", name, RegWriteM, RD_M);
    end
  endtask

  task automatic test_muldiv;
    nop(); run_muldiv(2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mul");
    nop(); run_muldiv(2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, "mulhu");
    nop(); run_muldiv(2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
    nop(); run_muldiv(2'b11, 32'd5, 32'd0, 32'd5, "remu_by0");
    nop();
  endtask

  task automatic test_back_to_back;
    nop();
    run_muldiv(2'b10, 32'd100, 32'd7, 32'd14, "divu");
    run_muldiv(2'b11, 32'd100, 32'd7, 32'd2, "remu");
    nop();
    step();
  endtask

  task automatic test_rst_mid;
    nop();
    MulDivE = 1; MulDivOpE = 2'b00; RD1_E = 3; RD2_E = 4; RegWriteE = 1;
    step();
    repeat (10) step();
    rst = 1'b1;
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", StallE); end
    total++; if (ALU_ResultM !== 32'h0) begin bad++; $display("FAIL rstmid_alu got=%h exp=0", ALU_ResultM); end
    nop();
    #2 rst = 1'b0;
    step();
    step();
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", StallE); end
    total++; if (ALU_ResultM !== 32'h0) begin bad++; $display("FAIL rstmid_noresult got=%h exp=0", ALU_ResultM); end
  endtask

  task automatic test_flush_busy;
    nop();
    MulDivE = 1; MulDivOpE = 2'b10; RD1_E = 100; RD2_E = 7; RegWriteE = 1;
    step();
    repeat (20) step();
    FlushE = 1;
    step();
    nop();
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL flush_busy_stall got=%b exp=0", StallE); end
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL flush_busy_write got=%b exp=0", RegWriteM); end
    step();
    total++; if (ALU_ResultM !== 32'h0) begin bad++; $display("FAIL flush_busy_result got=%h exp=0", ALU_ResultM); end
    run_muldiv(2'b00, 32'd7, 32'd6, 32'd42, "mul_after_flush");
    nop();
  endtask

  task automatic test_flush_start;
    nop();
    MulDivE = 1; MulDivOpE = 2'b00; RD1_E = 3; RD2_E = 4; RegWriteE = 1; FlushE = 1;
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL flush_start_stall got=%b exp=0", StallE); end
    step();
    nop();
    #1;
    total++; if (StallE !== 1'b0) begin bad++; $display("FAIL flush_start_idle got=%b exp=0", StallE); end
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL flush_start_write got=%b exp=0", RegWriteM); end
  endtask

  initial begin
    rst = 1'b1;
    nop();
    test_reset();
    test_add();
    test_async_reset();
    test_alu_ops();
    test_branch();
    test_forward();
    test_muldiv();
    test_back_to_back();
    test_rst_mid();
    test_flush_busy();
    test_flush_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
